ram_portb_arbiter: RTL and testbench
====================================

# ram_portb_arbiter

Shares the otherwise-unused port B of the CPU's 1K×16 dual-port RAM between two bus requesters: requester 0 is the display/video fetch and requester 1 is the I/O DMA. Each cycle the block grants at most one request, drives the RAM port B address, data and write-enable, and returns read data with a registered valid strobe. Port A stays owned by the CPU datapath and is not touched by this block.

## Interface
Parameters:
- ADDR_WIDTH, 10, RAM word-address width
- DATA_WIDTH, 16, RAM word width

Ports:
- Clk  in  1  system clock; all state updates on the rising edge
- Rst  in  1  asynchronous, active-low reset
- req0 / req1  in  1  request from requester 0 / 1; held high until the matching grant
- we0 / we1  in  1  1 = write, 0 = read; stable while req is high
- addr0 / addr1  in  ADDR_WIDTH  word address; stable while req is high
- wdata0 / wdata1  in  DATA_WIDTH  write data; stable while req is high
- gnt0 / gnt1  out  1  combinational grant; request accepted in the cycle gnt is high
- rvalid0 / rvalid1  out  1  registered; read data valid for that requester
- rdata  out  DATA_WIDTH  shared read data, equal to ram_q
- ram_addr  out  ADDR_WIDTH  to RAM addr_b
- ram_data  out  DATA_WIDTH  to RAM data_b
- ram_we  out  1  to RAM we_b
- ram_q  in  DATA_WIDTH  from RAM q_b_out, registered inside the RAM (1-cycle read latency)

## Operation
- State: priority pointer `last` (1 bit, last requester served), read-return owner register `rd_own` (2 bits: none/0/1).
- Arbitration, evaluated combinationally every cycle:
  - Neither req: no grant; ram_we = 0; ram_addr and ram_data hold their last driven values.
  - One req: that requester is granted.
  - Both req: the requester that is not `last` is granted (round-robin).
- For the granted requester k: ram_addr = addrk, ram_data = wdatak, ram_we = wek. gntk = 1 for exactly that cycle.
- On the rising edge ending a grant cycle: `last` ← k. If wek = 0, `rd_own` ← k; otherwise `rd_own` ← none.
- When `rd_own` = k, rvalidk = 1 and rdata carries the word. Writes never produce an rvalid.
- Back-to-back grants are allowed every cycle. The read pipeline is one deep and overlaps the next grant.
- At most one of gnt0/gnt1 is high. At most one of rvalid0/rvalid1 is high.
- Requester protocol violations are not checked. If req drops before its grant, it is simply not served.

## Timing
- Reset (Rst low, asynchronous): `last` = 1, so requester 0 wins the first contended cycle. `rd_own` = none; rvalid0 = rvalid1 = 0; ram_we = 0; ram_addr = 0; ram_data = 0. gnt0/gnt1 are forced 0 while Rst is low.
- Grant latency: 0 cycles. gnt asserts in the same cycle as req if the requester wins.
- Read latency: request granted in cycle N; rvalid high and rdata valid in cycle N+1 only.
- Worst-case wait under round-robin with both requesters continuous: 1 cycle. The requesters alternate 0,1,0,1…
- Reset asserted mid-read: the pending rvalid is dropped and never delivered after reset releases.
- Same address written by port B and read by port A in the same cycle: RAM behaviour governs. Port A read-during-write data is undefined and is a software responsibility.

## Configuration
- RAM_ARB_FIXED_PRIORITY_EN:
  - Defined: requester 0 always wins contention. `last` is not used. Requester 1 is served only in cycles with req0 = 0 (display fetch is never stalled).
  - Undefined (default): round-robin as described above.

## Test plan
- Single read: after reset, req0=1, we0=0, addr0=0x005, RAM[5]=0xBEEF → gnt0 in cycle N; rvalid0=1 and rdata=0xBEEF in N+1 only; rvalid1 stays 0.
- Single write: req1=1, we1=1, addr1=0x3FF, wdata1=0x1234 → gnt1 and ram_we=1, ram_addr=0x3FF, ram_data=0x1234 in that cycle. No rvalid. A later read of 0x3FF returns 0x1234.
- Contention, round-robin: req0 and req1 held high for 4 cycles, both reads of 0x010/0x020 → grants 0,1,0,1; rvalid pattern lags by one cycle (0,1,0,1); rdata alternates RAM[0x10]/RAM[0x20].
- Fixed priority (macro defined): same stimulus → gnt0 all 4 cycles, gnt1 never; gnt1 asserts in the first cycle req0 drops.
- Reset mid-read: grant read in cycle N, pull Rst low during N+1 before the edge → rvalid0/rvalid1 = 0 immediately and after release. The next contended cycle grants requester 0.
- Mixed back-to-back: write by 1 (0x040←0xA5A5) then read by 0 of 0x040 in the next cycle → read returns 0xA5A5 with rvalid0 one cycle after its grant.

Source files
------------

// File: rtl/ram_portb_arbiter.sv
// ---------------------------------------------------------------------------
// ram_portb_arbiter
//
// Shares port B of the CPU's 1Kx16 dual-port RAM between two requesters:
//   requester 0 = display/video fetch, requester 1 = I/O DMA.
// At most one request is granted per cycle. The granted requester drives the
// RAM port B address/data/write-enable combinationally. Read data comes back
// one cycle later on the shared rdata bus, qualified by a per-requester
// registered valid strobe.
//
// Ports:
//   Clk              system clock, rising edge
//   Rst              asynchronous active-low reset
//   req0/req1        requests, held high until granted
//   we0/we1          1 = write, 0 = read
//   addr0/addr1      word addresses
//   wdata0/wdata1    write data
//   gnt0/gnt1        combinational grants (request accepted this cycle)
//   rvalid0/rvalid1  registered read-data valid per requester
//   rdata            shared read data (straight from ram_q)
//   ram_addr/ram_data/ram_we  to RAM port B
//   ram_q            RAM port B registered read data (1-cycle latency)
//
// Configuration macro:
//   RAM_ARB_FIXED_PRIORITY_EN  defined: requester 0 always wins contention.
//                              undefined (default): round-robin.
// ---------------------------------------------------------------------------
module ram_portb_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_0    = 2'd1,
    OWN_1    = 2'd2
  } own_e;

  own_e                  rd_own_q, rd_own_d;
  logic [ADDR_WIDTH-1:0] addr_hold_q;
  logic [DATA_WIDTH-1:0] data_hold_q;

`ifndef RAM_ARB_FIXED_PRIORITY_EN
  // Last requester served; reset to 1 so requester 0 wins first contention.
  logic last_q, last_d;
`endif

  // Grants are gated by Rst so nothing is accepted while reset is asserted.
  always_comb begin
`ifdef RAM_ARB_FIXED_PRIORITY_EN
    gnt0 = Rst & req0;
    gnt1 = Rst & req1 & ~req0;
`else
    gnt0 = Rst & req0 & (~req1 | last_q);
    gnt1 = Rst & req1 & (~req0 | ~last_q);
`endif
  end

  // RAM port B drive. With no grant the bus holds its last driven value so
  // the RAM inputs do not toggle needlessly.
  always_comb begin
    ram_addr = addr_hold_q;
    ram_data = data_hold_q;
    ram_we   = 1'b0;
    rd_own_d = OWN_NONE;
    if (gnt0) begin
      ram_addr = addr0;
      ram_data = wdata0;
      ram_we   = we0;
      rd_own_d = we0 ? OWN_NONE : OWN_0;
    end else if (gnt1) begin
      ram_addr = addr1;
      ram_data = wdata1;
      ram_we   = we1;
      rd_own_d = we1 ? OWN_NONE : OWN_1;
    end
  end

`ifndef RAM_ARB_FIXED_PRIORITY_EN
  always_comb begin
    last_d = last_q;
    if (gnt0)      last_d = 1'b0;
    else if (gnt1) last_d = 1'b1;
  end
`endif

  // Grant stage -> read-return stage
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      rd_own_q    <= OWN_NONE;
      addr_hold_q <= '0;
      data_hold_q <= '0;
`ifndef RAM_ARB_FIXED_PRIORITY_EN
      last_q      <= 1'b1;
`endif
    end else begin
      rd_own_q    <= rd_own_d;
      addr_hold_q <= ram_addr;
      data_hold_q <= ram_data;
`ifndef RAM_ARB_FIXED_PRIORITY_EN
      last_q      <= last_d;
`endif
    end
  end

  // Read data arrives from the RAM's output register in the cycle after the
  // grant, exactly when rd_own_q names its owner.
  assign rvalid0 = (rd_own_q == OWN_0);
  assign rvalid1 = (rd_own_q == OWN_1);
  assign rdata   = ram_q;

endmodule

// File: tb/tb_ram_portb_arbiter.sv
module tb_ram_portb_arbiter;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        req0, req1, we0, we1;
  logic [9:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, ram_we;
  logic [15:0] rdata, ram_data, ram_q;
  logic [9:0]  ram_addr;

  logic [15:0] mem [0:1023];

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic        who;
    logic [15:0] data;
  } exp_t;
  exp_t sb[$];

  ram_portb_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(16)) dut (
    .Clk(Clk), .Rst(Rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we),
    .ram_q(ram_q)
  );

  always #5 Clk = ~Clk;

  function automatic logic [15:0] pat(input int i);
    return 16'h7000 | 16'(i);
  endfunction

  // RAM port B model: synchronous write, registered read.
  initial for (int i = 0; i < 1024; i++) mem[i] <= (i == 5) ? 16'hBEEF : pat(i);
  always @(posedge Clk) begin
    if (ram_we) mem[ram_addr] <= ram_data;
    ram_q <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs already driven by the caller. Checks the read
  // return owed from the previous cycle, the grants, and optionally the bus.
  task automatic step(input string tag, input bit eg0, input bit eg1,
                      input bit rd, input logic [15:0] rdexp,
                      input bit chkbus, input logic [9:0] ea,
                      input logic [15:0] ed, input bit ewe);
    exp_t e;
    @(negedge Clk);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "/rvalid0"}, 32'(rvalid0), 32'(!e.who));
      chk({tag, "/rvalid1"}, 32'(rvalid1), 32'(e.who));
      chk({tag, "/rdata"},   32'(rdata),   32'(e.data));
    end else begin
      chk({tag, "/rvalid0"}, 32'(rvalid0), 32'd0);
      chk({tag, "/rvalid1"}, 32'(rvalid1), 32'd0);
    end
    chk({tag, "/gnt0"}, 32'(gnt0), 32'(eg0));
    chk({tag, "/gnt1"}, 32'(gnt1), 32'(eg1));
    if (chkbus) begin
      chk({tag, "/ram_addr"}, 32'(ram_addr), 32'(ea));
      chk({tag, "/ram_data"}, 32'(ram_data), 32'(ed));
      chk({tag, "/ram_we"},   32'(ram_we),   32'(ewe));
    end
    if (rd) begin
      e.who  = eg1;
      e.data = rdexp;
      sb.push_back(e);
    end
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Rst = 1'b0;
    req0 = 1'b1; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    #12;
    chk("reset/gnt0",     32'(gnt0),     32'd0);
    chk("reset/rvalid0",  32'(rvalid0),  32'd0);
    chk("reset/rvalid1",  32'(rvalid1),  32'd0);
    chk("reset/ram_we",   32'(ram_we),   32'd0);
    chk("reset/ram_addr", 32'(ram_addr), 32'd0);
    chk("reset/ram_data", 32'(ram_data), 32'd0);
    req0 = 1'b0;
    @(negedge Clk); Rst = 1'b1;
    @(posedge Clk); #1;

    // Single read by requester 0.
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'h005;
    step("rd0", 1, 0, 1, 16'hBEEF, 1, 10'h005, 16'h0000, 0);
    req0 = 1'b0;
    step("rd0+1", 0, 0, 0, 16'h0, 1, 10'h005, 16'h0000, 0);
    step("rd0+2", 0, 0, 0, 16'h0, 0, 10'h0, 16'h0, 0);

    // Single write by requester 1, then bus hold, then readback by 1.
    req1 = 1'b1; we1 = 1'b1; addr1 = 10'h3FF; wdata1 = 16'h1234;
    step("wr1", 0, 1, 0, 16'h0, 1, 10'h3FF, 16'h1234, 1);
    req1 = 1'b0;
    step("wr1+1", 0, 0, 0, 16'h0, 1, 10'h3FF, 16'h1234, 0);
    req1 = 1'b1; we1 = 1'b0; wdata1 = 16'h0000;
    step("rdback1", 0, 1, 1, 16'h1234, 1, 10'h3FF, 16'h0000, 0);
    req1 = 1'b0;
    step("rdback1+1", 0, 0, 0, 16'h0, 0, 10'h0, 16'h0, 0);

    // Contention: both read, held for 4 cycles.
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'h010;
    req1 = 1'b1; we1 = 1'b0; addr1 = 10'h020;
`ifdef RAM_ARB_FIXED_PRIORITY_EN
    step("cont0", 1, 0, 1, pat(16'h010), 1, 10'h010, 16'h0, 0);
    step("cont1", 1, 0, 1, pat(16'h010), 1, 10'h010, 16'h0, 0);
    step("cont2", 1, 0, 1, pat(16'h010), 1, 10'h010, 16'h0, 0);
    step("cont3", 1, 0, 1, pat(16'h010), 1, 10'h010, 16'h0, 0);
`else
    step("cont0", 1, 0, 1, pat(16'h010), 1, 10'h010, 16'h0, 0);
    step("cont1", 0, 1, 1, pat(16'h020), 1, 10'h020, 16'h0, 0);
    step("cont2", 1, 0, 1, pat(16'h010), 1, 10'h010, 16'h0, 0);
    step("cont3", 0, 1, 1, pat(16'h020), 1, 10'h020, 16'h0, 0);
`endif
    req0 = 1'b0;
    step("cont_drop0", 0, 1, 1, pat(16'h020), 1, 10'h020, 16'h0, 0);
    req1 = 1'b0;
    step("cont_drain", 0, 0, 0, 16'h0, 0, 10'h0, 16'h0, 0);

    // Mixed back-to-back: write by 1, then read of same word by 0.
    req1 = 1'b1; we1 = 1'b1; addr1 = 10'h040; wdata1 = 16'hA5A5;
    step("mix_wr1", 0, 1, 0, 16'h0, 1, 10'h040, 16'hA5A5, 1);
    req1 = 1'b0; we1 = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'h040;
    step("mix_rd0", 1, 0, 1, 16'hA5A5, 1, 10'h040, 16'h0000, 0);
    req0 = 1'b0;
    step("mix_drain", 0, 0, 0, 16'h0, 0, 10'h0, 16'h0, 0);

    // Reset asserted in the cycle a read would return.
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'h005;
    step("rst_rd", 1, 0, 1, 16'hBEEF, 0, 10'h0, 16'h0, 0);
    req0 = 1'b0;
    #2 Rst = 1'b0;
    #1;
    sb.delete();
    chk("rst_mid/rvalid0", 32'(rvalid0), 32'd0);
    chk("rst_mid/rvalid1", 32'(rvalid1), 32'd0);
    req0 = 1'b1; req1 = 1'b1; we1 = 1'b0;
    #1;
    chk("rst_mid/gnt0",     32'(gnt0),     32'd0);
    chk("rst_mid/gnt1",     32'(gnt1),     32'd0);
    chk("rst_mid/ram_we",   32'(ram_we),   32'd0);
    chk("rst_mid/ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_mid/ram_data", 32'(ram_data), 32'd0);
    req0 = 1'b0; req1 = 1'b0;
    @(negedge Clk); #1 Rst = 1'b1;
    @(posedge Clk); #1;
    step("rst_post", 0, 0, 0, 16'h0, 0, 10'h0, 16'h0, 0);
    req0 = 1'b1; addr0 = 10'h010;
    req1 = 1'b1; addr1 = 10'h020;
    step("rst_cont", 1, 0, 1, pat(16'h010), 1, 10'h010, 16'h0, 0);
    req0 = 1'b0; req1 = 1'b0;
    step("rst_drain", 0, 0, 0, 16'h0, 0, 10'h0, 16'h0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
